// File: rtl/fp_compare_pipe.sv
// ---------------------------------------------------------------------------
// fp_compare_pipe
//   Two-stage, multi-lane floating-point comparator with a valid/ready
//   handshake. Each lane compares a_i against b_i under one shared opcode
//   and returns a single result bit. The sideband tag travels with the
//   transaction.
//
//   Number format per lane (W = 1 + EXP_W + FRAC_W bits): {sign, exp, frac}.
//   exp is two's complement and frac is unsigned. Values are ordered by sign,
//   then by signed exponent, then by fraction. When both values are negative,
//   the magnitude order is reversed. exp == most-negative with frac == 0 is
//   zero, and +0 equals -0.
//
//   Stage 1 registers per-lane magnitude relations and sign/zero flags.
//   Stage 2 resolves the opcode into the registered outputs. When the output
//   stalls, both stages hold.
//
//   Optional feature: define FP_COMPARE_MINMAX_EN to add out_min/out_max.
//   These outputs give the per-lane smaller/larger operand, and a is
//   returned on a tie.
//
// Ports
//   clk         clock, all logic on posedge
//   rst         synchronous active-high reset
//   in_valid    request present
//   in_ready    request accepted when in_valid && in_ready
//   in_a, in_b  LANES packed operands, lane i at [i*W +: W]
//   in_op       0 LT, 1 LE, 2 GT, 3 GE, 4 EQ, 5 NE, 6/7 reserved
//   in_tag      sideband tag, returned unchanged
//   out_valid   result present
//   out_ready   downstream accepts when out_valid && out_ready
//   out_result  bit i = (a_i op b_i); all zero for reserved opcodes
//   out_tag     tag of the transaction on the output
//   out_op_err  transaction used a reserved opcode
//   out_min     (FP_COMPARE_MINMAX_EN) per-lane smaller operand
//   out_max     (FP_COMPARE_MINMAX_EN) per-lane larger operand
// ---------------------------------------------------------------------------
module fp_compare_pipe #(
  parameter int EXP_W  = 6,
  parameter int FRAC_W = 14,
  parameter int LANES  = 4,
  parameter int TAG_W  = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [LANES*(1+EXP_W+FRAC_W)-1:0]    in_a,
  input  logic [LANES*(1+EXP_W+FRAC_W)-1:0]    in_b,
  input  logic [2:0]                           in_op,
  input  logic [TAG_W-1:0]                     in_tag,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [LANES-1:0]                     out_result,
  output logic [TAG_W-1:0]                     out_tag,
  output logic                                 out_op_err
`ifdef FP_COMPARE_MINMAX_EN
  ,
  output logic [LANES*(1+EXP_W+FRAC_W)-1:0]    out_min,
  output logic [LANES*(1+EXP_W+FRAC_W)-1:0]    out_max
`endif
);

  localparam int W = 1 + EXP_W + FRAC_W;
  localparam logic [EXP_W-1:0] EXP_MIN = {1'b1, {(EXP_W-1){1'b0}}};

  typedef enum logic [2:0] {
    OP_LT = 3'd0,
    OP_LE = 3'd1,
    OP_GT = 3'd2,
    OP_GE = 3'd3,
    OP_EQ = 3'd4,
    OP_NE = 3'd5
  } op_e;

  // Turns the lane's value relation into the result bit for this opcode.
  // Reserved opcodes return 0.
  function automatic logic resolve(input logic [2:0] op, input logic lt, input logic eq);
    case (op)
      OP_LT:   resolve = lt;
      OP_LE:   resolve = lt | eq;
      OP_GT:   resolve = ~lt & ~eq;
      OP_GE:   resolve = ~lt;
      OP_EQ:   resolve = eq;
      OP_NE:   resolve = ~eq;
      default: resolve = 1'b0;
    endcase
  endfunction

  // Handshake: any stall on the output freezes the whole pipe.
  logic stall;
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  // -------------------------------------------------------------------------
  // Stage 1: per-lane magnitude relation and sign/zero flags
  // -------------------------------------------------------------------------
  logic [LANES-1:0] c_mag_lt, c_mag_eq, c_sign_a, c_sign_b, c_zero_a, c_zero_b;

  for (genvar i = 0; i < LANES; i++) begin : g_s1
    logic [EXP_W-1:0]  exp_a, exp_b;
    logic [FRAC_W-1:0] frac_a, frac_b;

    assign exp_a  = in_a[i*W+FRAC_W +: EXP_W];
    assign exp_b  = in_b[i*W+FRAC_W +: EXP_W];
    assign frac_a = in_a[i*W +: FRAC_W];
    assign frac_b = in_b[i*W +: FRAC_W];

    assign c_sign_a[i] = in_a[i*W+W-1];
    assign c_sign_b[i] = in_b[i*W+W-1];
    assign c_zero_a[i] = (exp_a == EXP_MIN) && (frac_a == '0);
    assign c_zero_b[i] = (exp_b == EXP_MIN) && (frac_b == '0);
    assign c_mag_eq[i] = (exp_a == exp_b) && (frac_a == frac_b);
    assign c_mag_lt[i] = ($signed(exp_a) < $signed(exp_b)) ||
                         ((exp_a == exp_b) && (frac_a < frac_b));
  end

  logic                 s1_valid;
  logic [LANES-1:0]     s1_mag_lt, s1_mag_eq, s1_sign_a, s1_sign_b, s1_zero_a, s1_zero_b;
  logic [2:0]           s1_op;
  logic [TAG_W-1:0]     s1_tag;
`ifdef FP_COMPARE_MINMAX_EN
  logic [LANES*W-1:0]   s1_a, s1_b;
`endif

  // NOTE: sequential state is written with non-blocking assignments only.
  // Then every register samples values from before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (!stall) begin
      s1_valid <= in_valid;
    end
  end

  // NOTE: datapath registers have no reset. The stage-valid bit alone
  // decides whether their contents mean anything.
  always_ff @(posedge clk) begin
    if (!stall) begin
      s1_mag_lt <= c_mag_lt;
      s1_mag_eq <= c_mag_eq;
      s1_sign_a <= c_sign_a;
      s1_sign_b <= c_sign_b;
      s1_zero_a <= c_zero_a;
      s1_zero_b <= c_zero_b;
      s1_op     <= in_op;
      s1_tag    <= in_tag;
`ifdef FP_COMPARE_MINMAX_EN
      s1_a      <= in_a;
      s1_b      <= in_b;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Stage 2: resolve the value order and the opcode
  // -------------------------------------------------------------------------
  logic [LANES-1:0] c_result;
  logic             c_op_err;
`ifdef FP_COMPARE_MINMAX_EN
  logic [LANES*W-1:0] c_min, c_max;
`endif

  assign c_op_err = (s1_op > 3'd5);

  for (genvar i = 0; i < LANES; i++) begin : g_s2
    logic sign_a_eff, sign_b_eff, lane_lt, lane_eq;

    // A zero counts as positive here. Its magnitude is already the smallest
    // possible, so -0 then orders exactly like +0.
    assign sign_a_eff = s1_sign_a[i] & ~s1_zero_a[i];
    assign sign_b_eff = s1_sign_b[i] & ~s1_zero_b[i];

    assign lane_eq = (sign_a_eff == sign_b_eff) & s1_mag_eq[i];
    // Signs differ: a is smaller exactly when a is negative.
    // Both negative: the larger magnitude is the smaller value.
    assign lane_lt = (sign_a_eff != sign_b_eff) ? sign_a_eff :
                     (sign_a_eff ? ~(s1_mag_lt[i] | s1_mag_eq[i]) : s1_mag_lt[i]);

    assign c_result[i] = resolve(s1_op, lane_lt, lane_eq);

`ifdef FP_COMPARE_MINMAX_EN
    // On a tie, a is returned from both min and max.
    assign c_min[i*W +: W] = (~lane_lt & ~lane_eq) ? s1_b[i*W +: W] : s1_a[i*W +: W];
    assign c_max[i*W +: W] = lane_lt               ? s1_b[i*W +: W] : s1_a[i*W +: W];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
      out_op_err <= 1'b0;
`ifdef FP_COMPARE_MINMAX_EN
      out_min    <= '0;
      out_max    <= '0;
`endif
    end else if (!stall) begin
      out_valid  <= s1_valid;
      out_result <= c_op_err ? '0 : c_result;
      out_tag    <= s1_tag;
      out_op_err <= c_op_err;
`ifdef FP_COMPARE_MINMAX_EN
      out_min    <= c_min;
      out_max    <= c_max;
`endif
    end
  end

endmodule

// File: tb/tb_fp_compare_pipe.sv
// ---------------------------------------------------------------------------
// tb_fp_compare_pipe
//   Self-checking bench for fp_compare_pipe. The scoreboard predicts every
//   output from a reference model. The model maps each operand onto a signed
//   integer key that has the same order as the floating-point value, and it
//   compares those keys with plain arithmetic. Directed steps cover latency,
//   signed and zero ordering, stall behaviour, reserved opcodes and reset.
//   A randomized phase with random handshakes follows them.
//   Define FP_COMPARE_MINMAX_EN to also check out_min/out_max.
// ---------------------------------------------------------------------------
module tb_fp_compare_pipe;

  localparam int EXP_W  = 6;
  localparam int FRAC_W = 14;
  localparam int LANES  = 4;
  localparam int TAG_W  = 8;
  localparam int W      = 1 + EXP_W + FRAC_W;
  localparam logic [EXP_W-1:0] EXP_MIN = {1'b1, {(EXP_W-1){1'b0}}};

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [LANES*W-1:0]   in_a, in_b;
  logic [2:0]           in_op;
  logic [TAG_W-1:0]     in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic [LANES-1:0]     out_result;
  logic [TAG_W-1:0]     out_tag;
  logic                 out_op_err;
`ifdef FP_COMPARE_MINMAX_EN
  logic [LANES*W-1:0]   out_min, out_max;
`endif

  fp_compare_pipe #(
    .EXP_W(EXP_W), .FRAC_W(FRAC_W), .LANES(LANES), .TAG_W(TAG_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .out_op_err (out_op_err)
`ifdef FP_COMPARE_MINMAX_EN
    ,
    .out_min    (out_min),
    .out_max    (out_max)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: each value becomes a signed integer key with the same order
  // ---------------------------------------------------------------------------
  function automatic longint key(input logic [W-1:0] v);
    logic signed [EXP_W-1:0] e_f;
    int     e;
    longint mag;
    e_f = v[W-2 -: EXP_W];
    e   = e_f;
    // The smallest exponent with a zero fraction maps to 0, so both zeros land on 0.
    mag = longint'(e + 2**(EXP_W-1)) * (longint'(1) << FRAC_W) + longint'(v[FRAC_W-1:0]);
    return v[W-1] ? -mag : mag;
  endfunction

  typedef struct {
    logic [LANES-1:0]   res;
    logic [TAG_W-1:0]   tag;
    logic               err;
    logic [LANES*W-1:0] mn;
    logic [LANES*W-1:0] mx;
  } exp_t;

  function automatic exp_t model(input logic [LANES*W-1:0] a, input logic [LANES*W-1:0] b,
                                 input logic [2:0] op, input logic [TAG_W-1:0] tag);
    exp_t   r;
    longint ka, kb;
    r.tag = tag;
    r.err = (op >= 3'd6);
    r.res = '0;
    r.mn  = '0;
    r.mx  = '0;
    for (int i = 0; i < LANES; i++) begin
      ka = key(a[i*W +: W]);
      kb = key(b[i*W +: W]);
      case (op)
        3'd0:    r.res[i] = (ka <  kb);
        3'd1:    r.res[i] = (ka <= kb);
        3'd2:    r.res[i] = (ka >  kb);
        3'd3:    r.res[i] = (ka >= kb);
        3'd4:    r.res[i] = (ka == kb);
        3'd5:    r.res[i] = (ka != kb);
        default: r.res[i] = 1'b0;
      endcase
      r.mn[i*W +: W] = (kb < ka) ? b[i*W +: W] : a[i*W +: W];
      r.mx[i*W +: W] = (ka < kb) ? b[i*W +: W] : a[i*W +: W];
    end
    return r;
  endfunction

  // Random operand pairs, biased toward equal values, sign flips and mixed zeros.
  task automatic gen_pair(output logic [LANES*W-1:0] a, output logic [LANES*W-1:0] b);
    logic [31:0] r1, r2;
    logic [W-1:0] va, vb;
    for (int i = 0; i < LANES; i++) begin
      r1 = $urandom;
      r2 = $urandom;
      va = r1[W-1:0];
      vb = r2[W-1:0];
      case ($urandom_range(0, 7))
        0: vb = va;
        1: vb = {~va[W-1], va[W-2:0]};
        2: begin
          va = {r1[0], EXP_MIN, {FRAC_W{1'b0}}};
          vb = {r1[1], EXP_MIN, {FRAC_W{1'b0}}};
        end
        3: vb = {va[W-1:FRAC_W], r2[FRAC_W-1:0]};
        4: va = {r1[0], EXP_MIN, {FRAC_W{1'b0}}};
        default: ;
      endcase
      a[i*W +: W] = va;
      b[i*W +: W] = vb;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard: sample at negedge, away from the active edge
  // ---------------------------------------------------------------------------
  exp_t             exp_q[$];
  exp_t             cur;
  logic             prev_stall = 1'b0;
  logic [LANES-1:0] prev_res;
  logic [TAG_W-1:0] prev_tag;
  logic             prev_err;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_hold_valid",  out_valid,  1'b1);
        check("stall_hold_result", out_result, prev_res);
        check("stall_hold_tag",    out_tag,    prev_tag);
        check("stall_hold_err",    out_op_err, prev_err);
      end
      check("in_ready_vs_stall", in_ready, !(out_valid && !out_ready));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_output", out_valid, 1'b0);
        end else begin
          cur = exp_q.pop_front();
          check("sb_tag",    out_tag,    cur.tag);
          check("sb_result", out_result, cur.res);
          check("sb_op_err", out_op_err, cur.err);
`ifdef FP_COMPARE_MINMAX_EN
          check("sb_min", out_min, cur.mn);
          check("sb_max", out_max, cur.mx);
`endif
        end
      end
      if (in_valid && in_ready)
        exp_q.push_back(model(in_a, in_b, in_op, in_tag));
      prev_stall = out_valid && !out_ready;
      prev_res   = out_result;
      prev_tag   = out_tag;
      prev_err   = out_op_err;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver helpers (inputs change #1 after posedge)
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] a0, input logic [W-1:0] b0,
                      input logic [2:0] op, input logic [TAG_W-1:0] tag);
    logic [LANES*W-1:0] a, b;
    logic accepted;
    gen_pair(a, b);
    a[W-1:0] = a0;
    b[W-1:0] = b0;
    in_a = a;
    in_b = b;
    in_op = op;
    in_tag = tag;
    in_valid = 1'b1;
    accepted = 1'b0;
    for (int n = 0; n < 50 && !accepted; n++) begin
      @(negedge clk);
      accepted = in_ready;
      step();
    end
    in_valid = 1'b0;
    if (!accepted) check("send_timeout", in_ready, 1'b1);
  endtask

  // Returns at the negedge where out_valid is first seen high.
  task automatic wait_out();
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk);
      seen = out_valid;
    end
    if (!seen) check("out_timeout", out_valid, 1'b1);
  endtask

  logic [W-1:0] p_one, p_one5, m_two, m_one, p_zero, m_zero, p_three, m_seven, rnd;
  logic [LANES*W-1:0] ra, rb;
  logic [31:0] r32;

  initial begin
    p_one   = {1'b0, EXP_W'(0), FRAC_W'(0)};
    p_one5  = {1'b0, EXP_W'(0), FRAC_W'('h2000)};
    m_two   = {1'b1, EXP_W'(1), FRAC_W'(0)};
    m_one   = {1'b1, EXP_W'(0), FRAC_W'(0)};
    p_zero  = {1'b0, EXP_MIN, FRAC_W'(0)};
    m_zero  = {1'b1, EXP_MIN, FRAC_W'(0)};
    p_three = {1'b0, EXP_W'(1), FRAC_W'('h2000)};
    m_seven = {1'b1, EXP_W'(2), FRAC_W'('h3000)};

    rst = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_op = '0;
    in_tag = '0;
    out_ready = 1'b1;

    // Reset state
    repeat (2) step();
    @(negedge clk);
    check("rst_out_valid",  out_valid,  1'b0);
    check("rst_out_result", out_result, '0);
    check("rst_out_tag",    out_tag,    '0);
    check("rst_out_op_err", out_op_err, 1'b0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    step();

    // Latency: +1.0 < +1.5 shows up exactly two cycles after acceptance
    send(p_one, p_one5, 3'd0, 8'h33);
    @(negedge clk);
    check("lat_cycle1_valid", out_valid, 1'b0);
    step();
    @(negedge clk);
    check("lat_cycle2_valid", out_valid, 1'b1);
    check("lat_lt_lane0",     out_result[0], 1'b1);
    check("lat_tag",          out_tag, 8'h33);
    step();

    // Signed ordering and signed zeros
    send(m_two, m_one, 3'd2, 8'h20);
    wait_out();
    check("neg_gt", out_result[0], 1'b0);
    step();
    send(m_two, m_one, 3'd0, 8'h21);
    wait_out();
    check("neg_lt", out_result[0], 1'b1);
    step();
    send(p_zero, m_zero, 3'd4, 8'h22);
    wait_out();
    check("zero_eq", out_result[0], 1'b1);
    step();
    send(p_zero, m_zero, 3'd0, 8'h23);
    wait_out();
    check("zero_lt", out_result[0], 1'b0);
    step();

    // Reserved opcode
    r32 = $urandom;
    rnd = r32[W-1:0];
    send(rnd, p_one, 3'd6, 8'hA5);
    wait_out();
    check("rsv_result", out_result, 4'b0000);
    check("rsv_op_err", out_op_err, 1'b1);
    check("rsv_tag",    out_tag, 8'hA5);
    step();

`ifdef FP_COMPARE_MINMAX_EN
    send(p_three, m_seven, 3'd0, 8'h40);
    wait_out();
    check("mm_min", out_min[W-1:0], m_seven);
    check("mm_max", out_max[W-1:0], p_three);
    step();
    send(p_three, p_three, 3'd4, 8'h41);
    wait_out();
    check("mm_tie_min", out_min[W-1:0], p_three);
    check("mm_tie_max", out_max[W-1:0], p_three);
    step();
`endif
    repeat (3) step();

    // Back-to-back with out_ready low in cycles 3..5; scoreboard checks order
    fork
      begin
        for (int t = 1; t <= 4; t++) begin
          r32 = $urandom;
          send(r32[W-1:0], r32[W+10:11], 3'(t % 6), TAG_W'(t));
        end
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check("stall_in_ready_low", in_ready, 1'b0);
          step();
        end
        out_ready = 1'b1;
      end
    join
    repeat (6) step();
    check("stall_drained", exp_q.size(), 0);

    // Reset with two transactions in flight
    send(p_one, p_one5, 3'd1, 8'h10);
    send(m_one, p_one, 3'd3, 8'h11);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_flush_valid", out_valid, 1'b0);
    check("rst_flush_ready", in_ready,  1'b1);
    step();
    @(negedge clk);
    check("rst_no_stale_1", out_valid, 1'b0);
    step();
    @(negedge clk);
    check("rst_no_stale_2", out_valid, 1'b0);
    step();

    // Randomized traffic with random handshakes
    for (int n = 0; n < 400; n++) begin
      gen_pair(ra, rb);
      in_a = ra;
      in_b = rb;
      in_op = 3'($urandom_range(0, 7));
      in_tag = TAG_W'($urandom);
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (6) step();
    check("final_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
